alarm_ringer: RTL and testbench

ALARM_RINGER -- requirements
Module: alarm_ringer

---
 rtl/alarm_ringer.sv | 228 ++++++++++++++++++++++
 tb/tb_alarm_ringer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// alarm_ringer: alarm ring sequencer. Rings a gated tone once the time-compare
// block flags a match, and stops on STOP_KEY, on an unattended timeout, or via
// snooze. After ringing it holds the compare clear for two second ticks so
// the compare cannot re-fire within the matching second.
//
// Build option: define ALARM_SNOOZE_EN to include the SNOOZE state. Without it,
// SNOOZE_KEY is ignored and SNOOZE_CNT reads 0.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset
//   TICK_1HZ     one-CLK pulse per second
//   ALARM_DOING  sticky match flag from the time-compare block
//   STOP_KEY     debounced level; rising edge stops ringing or snooze
//   SNOOZE_KEY   debounced level; rising edge snoozes while ringing
//   BUZZER       gated tone to the piezo driver (registered)
//   RINGING      high while ringing (registered)
//   ALARM_CLEAR  clear to the time-compare block (registered)
//   SNOOZE_CNT   snoozes used in the current alarm event
module alarm_ringer #(
    parameter int unsigned TONE_DIV     = 25000,
    parameter int unsigned RING_TIMEOUT = 60,
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned SNOOZE_MAX   = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK_1HZ,
    input  logic       ALARM_DOING,
    input  logic       STOP_KEY,
    input  logic       SNOOZE_KEY,
    output logic       BUZZER,
    output logic       RINGING,
    output logic       ALARM_CLEAR,
    output logic [1:0] SNOOZE_CNT
);

    localparam int unsigned SEC_MAX = (RING_TIMEOUT > SNOOZE_SEC) ? RING_TIMEOUT : SNOOZE_SEC;
    localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);
    localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RING    = 2'd1,
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE  = 2'd3,
`endif
        S_HOLDOFF = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic                tone_q, tone_d;
    logic                beat_q, beat_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic                stop_prev_q, stop_prev_d;
    logic                armed_q, armed_d;
    logic                buzzer_q, buzzer_d;
    logic                ringing_q, ringing_d;
    logic                clear_q, clear_d;
    logic [SEC_W-1:0]    sec_inc;
    logic                stop_rise;

    // Key edges are suppressed on the first cycle after reset (armed_q low),
    // so a key already held through reset never looks like a fresh press.
    assign stop_rise = STOP_KEY & ~stop_prev_q & armed_q;
    assign sec_inc   = sec_q + SEC_W'(1);

`ifdef ALARM_SNOOZE_EN
    logic       snooze_prev_q, snooze_prev_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       snooze_rise;

    assign snooze_rise = SNOOZE_KEY & ~snooze_prev_q & armed_q;
    assign SNOOZE_CNT  = snooze_cnt_q;
`else
    logic unused_snooze;

    assign unused_snooze = ^{SNOOZE_KEY, 32'(SNOOZE_MAX)};
    assign SNOOZE_CNT    = 2'b00;
`endif

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            tone_cnt_q    <= '0;
            tone_q        <= 1'b0;
            beat_q        <= 1'b1;
            sec_q         <= '0;
            stop_prev_q   <= 1'b0;
            armed_q       <= 1'b0;
            buzzer_q      <= 1'b0;
            ringing_q     <= 1'b0;
            clear_q       <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_prev_q <= 1'b0;
            snooze_cnt_q  <= 2'd0;
`endif
        end else begin
            state_q       <= state_d;
            tone_cnt_q    <= tone_cnt_d;
            tone_q        <= tone_d;
            beat_q        <= beat_d;
            sec_q         <= sec_d;
            stop_prev_q   <= stop_prev_d;
            armed_q       <= armed_d;
            buzzer_q      <= buzzer_d;
            ringing_q     <= ringing_d;
            clear_q       <= clear_d;
`ifdef ALARM_SNOOZE_EN
            snooze_prev_q <= snooze_prev_d;
            snooze_cnt_q  <= snooze_cnt_d;
`endif
        end
    end

    // Next state, counters and registered-output values
    always_comb begin
        state_d     = state_q;
        tone_cnt_d  = tone_cnt_q;
        tone_d      = tone_q;
        beat_d      = beat_q;
        sec_d       = sec_q;
        stop_prev_d = STOP_KEY;
        armed_d     = 1'b1;
`ifdef ALARM_SNOOZE_EN
        snooze_prev_d = SNOOZE_KEY;
        snooze_cnt_d  = snooze_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Hold tone/beat/second counter at their ring-entry values.
                tone_cnt_d = '0;
                tone_d     = 1'b0;
                beat_d     = 1'b1;
                sec_d      = '0;
                if (ALARM_DOING) begin
                    state_d = S_RING;
                end
            end

            S_RING: begin
                if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + TONE_W'(1);
                end
                if (TICK_1HZ) begin
                    beat_d = ~beat_q;
                    sec_d  = sec_inc;
                end
                // Priority: stop edge, then timeout, then snooze edge.
                if (stop_rise) begin
                    state_d = S_HOLDOFF;
                    sec_d   = '0;
                end else if (TICK_1HZ && (sec_inc == SEC_W'(RING_TIMEOUT))) begin
                    state_d = S_HOLDOFF;
                    sec_d   = '0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze_rise && (snooze_cnt_q < 2'(SNOOZE_MAX))) begin
                    state_d      = S_SNOOZE;
                    sec_d        = '0;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                end
`endif
            end

`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (stop_rise) begin
                    state_d = S_HOLDOFF;
                    sec_d   = '0;
                end else if (TICK_1HZ) begin
                    if (sec_inc == SEC_W'(SNOOZE_SEC)) begin
                        state_d    = S_RING;
                        sec_d      = '0;
                        beat_d     = 1'b1;
                        tone_d     = 1'b0;
                        tone_cnt_d = '0;
                    end else begin
                        sec_d = sec_inc;
                    end
                end
            end
`endif

            S_HOLDOFF: begin
                // Leave on the second tick after entry.
                if (TICK_1HZ) begin
                    if (sec_q != '0) begin
                        state_d = S_IDLE;
                        sec_d   = '0;
                    end else begin
                        sec_d = SEC_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ALARM_SNOOZE_EN
        if (state_d == S_IDLE) begin
            snooze_cnt_d = 2'd0;
        end
`endif

        // Outputs follow the next state so BUZZER drops on the edge leaving RING.
        ringing_d = (state_d == S_RING);
`ifdef ALARM_SNOOZE_EN
        clear_d   = (state_d == S_HOLDOFF) || (state_d == S_SNOOZE);
`else
        clear_d   = (state_d == S_HOLDOFF);
`endif
        buzzer_d  = ringing_d & tone_d & beat_d;
    end

    assign BUZZER      = buzzer_q;
    assign RINGING     = ringing_q;
    assign ALARM_CLEAR = clear_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: directed bench for alarm_ringer with a small expected-value
// scoreboard. Runs with TONE_DIV=4, RING_TIMEOUT=5, SNOOZE_SEC=3, SNOOZE_MAX=2
// and a one-second tick every 100 CLK. Snooze scenarios follow ALARM_SNOOZE_EN.
module tb_alarm_ringer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TICK_1HZ;
    logic       ALARM_DOING;
    logic       STOP_KEY;
    logic       SNOOZE_KEY;
    logic       BUZZER;
    logic       RINGING;
    logic       ALARM_CLEAR;
    logic [1:0] SNOOZE_CNT;

    always #5 CLK = ~CLK;

    alarm_ringer #(
        .TONE_DIV    (4),
        .RING_TIMEOUT(5),
        .SNOOZE_SEC  (3),
        .SNOOZE_MAX  (2)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .TICK_1HZ   (TICK_1HZ),
        .ALARM_DOING(ALARM_DOING),
        .STOP_KEY   (STOP_KEY),
        .SNOOZE_KEY (SNOOZE_KEY),
        .BUZZER     (BUZZER),
        .RINGING    (RINGING),
        .ALARM_CLEAR(ALARM_CLEAR),
        .SNOOZE_CNT (SNOOZE_CNT)
    );

    // Expected output vector is {RINGING, BUZZER, ALARM_CLEAR, SNOOZE_CNT}.
    typedef struct packed {
        logic [4:0] mask;
        logic [4:0] val;
    } exp_t;

    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] NOBUZ = 5'b10111;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;

    // One clock edge; TICK_1HZ is high for the edge where phase wraps.
    task automatic edge_step();
        TICK_1HZ = (phase == 99);
        phase    = (phase == 99) ? 0 : phase + 1;
        @(posedge CLK);
        #1;
    endtask

    // Advance until the next edge is a tick edge.
    task automatic run_to_tick();
        while (phase != 99) edge_step();
    endtask

    task automatic push_exp(input logic r, input logic b, input logic c,
                            input logic [1:0] n, input logic [4:0] mask);
        exp_t e;
        e.mask = mask;
        e.val  = {r, b, c, n};
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t       e;
        logic [4:0] obs;
        obs = {RINGING, BUZZER, ALARM_CLEAR, SNOOZE_CNT};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert ((obs & e.mask) === (e.val & e.mask)) else begin
                errors++;
                $error("FAIL %s: observed {ring,buz,clr,cnt}=%b expected %b mask %b",
                       tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic step_chk(input string tag, input logic r, input logic b, input logic c,
                            input logic [1:0] n, input logic [4:0] mask);
        push_exp(r, b, c, n, mask);
        edge_step();
        pop_chk(tag);
    endtask

    initial begin
        logic b;
        RESET       = 1'b1;
        TICK_1HZ    = 1'b0;
        ALARM_DOING = 1'b0;
        STOP_KEY    = 1'b0;
        SNOOZE_KEY  = 1'b0;

        // Reset state
        step_chk("reset_state", 1'b0, 1'b0, 1'b0, 2'd0, ALL);
        edge_step();
        RESET = 1'b0;
        step_chk("idle_after_reset", 1'b0, 1'b0, 1'b0, 2'd0, ALL);

        // Unattended ring: entry on a tick edge, tone waveform, timeout, holdoff
        run_to_tick();
        ALARM_DOING = 1'b1;
        step_chk("ring_entry", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        for (int k = 1; k < 200; k++) begin
            b = (k < 100) && (((k / 4) % 2) == 1);
            step_chk("ring_wave", 1'b1, b, 1'b0, 2'd0, ALL);
        end
        step_chk("ring_tick2", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        run_to_tick();
        step_chk("ring_tick3", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        run_to_tick();
        step_chk("ring_tick4", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        run_to_tick();
        step_chk("timeout_holdoff", 1'b0, 1'b0, 1'b1, 2'd0, ALL);
        ALARM_DOING = 1'b0;
        run_to_tick();
        step_chk("holdoff_tick1", 1'b0, 1'b0, 1'b1, 2'd0, ALL);
        run_to_tick();
        step_chk("holdoff_exit", 1'b0, 1'b0, 1'b0, 2'd0, ALL);
        step_chk("idle_stays", 1'b0, 1'b0, 1'b0, 2'd0, ALL);

`ifdef ALARM_SNOOZE_EN
        // Two snoozes, third ignored, then stop
        run_to_tick();
        ALARM_DOING = 1'b1;
        step_chk("ring_entry_snz", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        repeat (3) edge_step();
        SNOOZE_KEY = 1'b1;
        step_chk("snooze1", 1'b0, 1'b0, 1'b1, 2'd1, ALL);
        SNOOZE_KEY  = 1'b0;
        ALARM_DOING = 1'b0;
        run_to_tick();
        step_chk("snz1_t1", 1'b0, 1'b0, 1'b1, 2'd1, ALL);
        run_to_tick();
        step_chk("snz1_t2", 1'b0, 1'b0, 1'b1, 2'd1, ALL);
        run_to_tick();
        step_chk("snz1_back", 1'b1, 1'b0, 1'b0, 2'd1, ALL);
        repeat (2) edge_step();
        SNOOZE_KEY = 1'b1;
        step_chk("snooze2", 1'b0, 1'b0, 1'b1, 2'd2, ALL);
        SNOOZE_KEY = 1'b0;
        run_to_tick();
        step_chk("snz2_t1", 1'b0, 1'b0, 1'b1, 2'd2, ALL);
        run_to_tick();
        step_chk("snz2_t2", 1'b0, 1'b0, 1'b1, 2'd2, ALL);
        run_to_tick();
        step_chk("snz2_back", 1'b1, 1'b0, 1'b0, 2'd2, ALL);
        edge_step();
        SNOOZE_KEY = 1'b1;
        step_chk("snooze3_ignored", 1'b1, 1'b0, 1'b0, 2'd2, NOBUZ);
        step_chk("snooze3_hold", 1'b1, 1'b0, 1'b0, 2'd2, NOBUZ);
        SNOOZE_KEY = 1'b0;
        edge_step();
        STOP_KEY = 1'b1;
        step_chk("stop_cnt2", 1'b0, 1'b0, 1'b1, 2'd2, ALL);
        STOP_KEY = 1'b0;
        run_to_tick();
        step_chk("hold_snz_t1", 1'b0, 1'b0, 1'b1, 2'd2, ALL);
        run_to_tick();
        step_chk("idle_cnt_clear", 1'b0, 1'b0, 1'b0, 2'd0, ALL);

        // Stop and snooze edges in the same cycle: stop wins
        run_to_tick();
        ALARM_DOING = 1'b1;
        step_chk("ring_entry_same", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        edge_step();
        STOP_KEY   = 1'b1;
        SNOOZE_KEY = 1'b1;
        step_chk("stop_snooze_same", 1'b0, 1'b0, 1'b1, 2'd0, ALL);
        STOP_KEY    = 1'b0;
        SNOOZE_KEY  = 1'b0;
        ALARM_DOING = 1'b0;
        run_to_tick();
        edge_step();
        run_to_tick();
        step_chk("same_exit", 1'b0, 1'b0, 1'b0, 2'd0, ALL);
`else
        // Snooze key ignored while ringing, then stop
        run_to_tick();
        ALARM_DOING = 1'b1;
        step_chk("ring_entry_nosnz", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        repeat (2) edge_step();
        SNOOZE_KEY = 1'b1;
        step_chk("snooze_ignored", 1'b1, 1'b0, 1'b0, 2'd0, NOBUZ);
        step_chk("snooze_ignored_hold", 1'b1, 1'b0, 1'b0, 2'd0, NOBUZ);
        SNOOZE_KEY = 1'b0;
        edge_step();
        STOP_KEY = 1'b1;
        step_chk("stop_to_holdoff", 1'b0, 1'b0, 1'b1, 2'd0, ALL);
        STOP_KEY    = 1'b0;
        ALARM_DOING = 1'b0;
        run_to_tick();
        step_chk("hold_stop_t1", 1'b0, 1'b0, 1'b1, 2'd0, ALL);
        run_to_tick();
        step_chk("hold_stop_exit", 1'b0, 1'b0, 1'b0, 2'd0, ALL);
`endif

        // Reset mid-ring with STOP_KEY held: no clear pulse, no false stop later
        run_to_tick();
        ALARM_DOING = 1'b1;
        step_chk("ring_entry_rst", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        repeat (5) edge_step();
        RESET       = 1'b1;
        STOP_KEY    = 1'b1;
        ALARM_DOING = 1'b0;
        step_chk("reset_midring", 1'b0, 1'b0, 1'b0, 2'd0, ALL);
        RESET = 1'b0;
        step_chk("after_reset_idle", 1'b0, 1'b0, 1'b0, 2'd0, ALL);
        ALARM_DOING = 1'b1;
        step_chk("ring_post_reset", 1'b1, 1'b0, 1'b0, 2'd0, ALL);
        repeat (6) step_chk("no_false_stop", 1'b1, 1'b0, 1'b0, 2'd0, NOBUZ);
        STOP_KEY = 1'b0;
        edge_step();
        STOP_KEY = 1'b1;
        step_chk("stop_after_reset", 1'b0, 1'b0, 1'b1, 2'd0, ALL);
        STOP_KEY    = 1'b0;
        ALARM_DOING = 1'b0;
        edge_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
